// File: rtl/joybus_pkg.sv
// joybus_pkg: shared JOYBUS command codes, reply constants, bit-timing multipliers and device FSM states
package joybus_pkg;

   localparam logic [7:0]  JB_CMD_INFO   = 8'h00;
   localparam logic [7:0]  JB_CMD_POLL   = 8'h01;
   localparam logic [7:0]  JB_CMD_RESET  = 8'hFF;
   localparam logic [23:0] JB_INFO_REPLY = 24'h050002;

   localparam int JB_T1 = 1;
   localparam int JB_T2 = 2;
   localparam int JB_T3 = 3;
   localparam int JB_T4 = 4;

   typedef enum logic [2:0] {
      IDLE,
      RX_SAMPLE,
      RX_HIGH,
      RX_STOP,
      RSP_GAP,
      TX_BIT,
      TX_STOP,
      DISCARD
   } jb_dev_state_e;

endpackage

// File: rtl/joybus_device_if.sv
// joybus_device_if: controller-state input and command/status outputs of the JOYBUS device endpoint
interface joybus_device_if;

   logic [31:0] cntlr_state;
   logic        cmd_strobe;
   logic [7:0]  cmd_byte;
   logic        rsp_active;
   logic        frame_err;

   modport slave (
      input  cntlr_state,
      output cmd_strobe, cmd_byte, rsp_active, frame_err
   );

   modport master (
      output cntlr_state,
      input  cmd_strobe, cmd_byte, rsp_active, frame_err
   );

endinterface

// File: rtl/joybus_bit_encoder.sv
// joybus_bit_encoder: shifts out an MSB-aligned word as timed JOYBUS low/release bits plus a 2 us stop low
module joybus_bit_encoder
   import joybus_pkg::*;
#(
   parameter int US = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] data_i,
   input  logic [5:0]  nbits_i,
   output logic        drive_low_o,
   output logic        stop_o,
   output logic        done_o
);

   localparam int TW = $clog2(JB_T4 * US + 1);
   localparam logic [TW-1:0] T_ONE_LOW  = TW'(JB_T1 * US);
   localparam logic [TW-1:0] T_ZERO_LOW = TW'(JB_T3 * US);
   localparam logic [TW-1:0] T_BIT_END  = TW'(JB_T4 * US - 1);
   localparam logic [TW-1:0] T_STOP_END = TW'(JB_T2 * US - 1);

   logic          busy_q, busy_d;
   logic          stop_q, stop_d;
   logic [31:0]   sr_q, sr_d;
   logic [5:0]    left_q, left_d;
   logic [TW-1:0] t_q, t_d;
   logic          bit_end, stop_end;

   assign bit_end  = t_q == T_BIT_END;
   assign stop_end = t_q == T_STOP_END;

   // encoder state; async reset releases the line at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         stop_q <= 1'b0;
         sr_q   <= '0;
         left_q <= '0;
         t_q    <= '0;
      end else begin
         busy_q <= busy_d;
         stop_q <= stop_d;
         sr_q   <= sr_d;
         left_q <= left_d;
         t_q    <= t_d;
      end
   end

   // bit-cell timing: advance to the next bit every 4 us, then run a 2 us stop low
   always_comb begin
      busy_d = busy_q;
      stop_d = stop_q;
      sr_d   = sr_q;
      left_d = left_q;
      t_d    = t_q;
      if (start_i) begin
         busy_d = 1'b1;
         stop_d = 1'b0;
         sr_d   = data_i;
         left_d = nbits_i;
         t_d    = '0;
      end else if (busy_q && stop_q) begin
         t_d = t_q + 1'b1;
         if (stop_end) busy_d = 1'b0;
      end else if (busy_q) begin
         t_d = bit_end ? '0 : t_q + 1'b1;
         if (bit_end) begin
            sr_d   = sr_q << 1;
            left_d = (left_q == '0) ? left_q : left_q - 1'b1;
            stop_d = left_q <= 6'd1;
         end
      end
   end

   assign drive_low_o = busy_q && (stop_q || t_q < (sr_q[31] ? T_ONE_LOW : T_ZERO_LOW));
   assign stop_o      = stop_q;
   assign done_o      = busy_q && stop_q && stop_end;

endmodule

// File: rtl/joybus_device.sv
// joybus_device: N64-controller side JOYBUS endpoint answering info (0x00) and poll (0x01);
// define JOYBUS_DEV_RESET_CMD_EN to also answer 0xFF like 0x00
module joybus_device
   import joybus_pkg::*;
#(
   parameter int CLK_MHZ = 25,
   parameter int IDLE_US = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   inout  wire            JB,
   joybus_device_if.slave bus
);

   localparam int US       = CLK_MHZ;
   localparam int TICK_MAX = ((IDLE_US > 8) ? IDLE_US : 8) * US;
   localparam int TW       = $clog2(TICK_MAX + 1);
   localparam logic [TW-1:0] T_MAX      = TW'(TICK_MAX);
   localparam logic [TW-1:0] T_ONE      = TW'(JB_T1 * US);
   localparam logic [TW-1:0] T_SAMPLE   = TW'(JB_T2 * US);
   localparam logic [TW-1:0] T_GAP_END  = TW'(JB_T2 * US - 1);
   localparam logic [TW-1:0] T_LOW_MAX  = TW'(5 * US);
   localparam logic [TW-1:0] T_HIGH_MAX = TW'(8 * US);
   localparam logic [TW-1:0] T_IDLE_END = TW'(IDLE_US * US - 1);

   jb_dev_state_e state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [5:0]    bits_q, bits_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [31:0]   tx_q, tx_d;
   logic          fell_q, fell_d;
   logic          strobe_q, strobe_d;
   logic          err_q, err_d;
   logic          s1_q, s2_q, prev_q;
   logic          line, fall, rise, supported;
   logic          enc_start, enc_drive, enc_stop, enc_done;
   logic [5:0]    tx_bits;

   assign line    = s2_q;
   assign fall    = prev_q & ~s2_q;
   assign rise    = ~prev_q & s2_q;
   assign tx_bits = (cmd_q == JB_CMD_POLL) ? 6'd32 : 6'd24;

`ifdef JOYBUS_DEV_RESET_CMD_EN
   assign supported = cmd_q == JB_CMD_INFO || cmd_q == JB_CMD_POLL || cmd_q == JB_CMD_RESET;
`else
   assign supported = cmd_q == JB_CMD_INFO || cmd_q == JB_CMD_POLL;
`endif

   // state register plus line synchronizer (idles high like the pulled-up bus)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         prev_q   <= 1'b1;
         state_q  <= IDLE;
         tick_q   <= '0;
         bits_q   <= '0;
         rx_q     <= '0;
         cmd_q    <= '0;
         tx_q     <= '0;
         fell_q   <= 1'b0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         s1_q     <= JB;
         s2_q     <= s1_q;
         prev_q   <= s2_q;
         state_q  <= state_d;
         tick_q   <= tick_d;
         bits_q   <= bits_d;
         rx_q     <= rx_d;
         cmd_q    <= cmd_d;
         tx_q     <= tx_d;
         fell_q   <= fell_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   // next state: decode console bits by edge-relative timing, then sequence the reply
   always_comb begin
      state_d  = state_q;
      tick_d   = (tick_q == T_MAX) ? tick_q : tick_q + 1'b1;
      bits_d   = bits_q;
      rx_d     = rx_q;
      fell_d   = fell_q;
      strobe_d = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: if (fall) begin
            state_d = RX_SAMPLE;
            tick_d  = '0;
            bits_d  = '0;
         end
         RX_SAMPLE: if (tick_q == T_SAMPLE) begin
            rx_d   = {rx_q[6:0], line};
            bits_d = (bits_q == 6'h3F) ? bits_q : bits_q + 1'b1;
            if (line) tick_d = T_ONE;
            if (bits_q == 6'd7) begin
               state_d  = RX_STOP;
               strobe_d = 1'b1;
               fell_d   = 1'b0;
            end else begin
               state_d = RX_HIGH;
            end
         end
         RX_HIGH: begin
            if (fall) begin
               state_d = RX_SAMPLE;
               tick_d  = '0;
            end else if (rise) begin
               tick_d = '0;
            end else if (line ? tick_q >= T_HIGH_MAX : tick_q >= T_LOW_MAX) begin
               err_d   = 1'b1;
               state_d = DISCARD;
               tick_d  = '0;
            end
         end
         RX_STOP: begin
            if (fall && !fell_q) begin
               fell_d = 1'b1;
               tick_d = '0;
            end else if (rise && fell_q) begin
               state_d = supported ? RSP_GAP : DISCARD;
               tick_d  = '0;
            end else if (rise) begin
               tick_d = '0;
            end else if (line ? (!fell_q && tick_q >= T_HIGH_MAX) : tick_q >= T_LOW_MAX) begin
               err_d   = 1'b1;
               state_d = DISCARD;
               tick_d  = '0;
            end
         end
         RSP_GAP: if (tick_q == T_GAP_END) state_d = TX_BIT;
         TX_BIT:  if (enc_stop) state_d = TX_STOP;
         TX_STOP: if (enc_done) state_d = IDLE;
         DISCARD: begin
            if (!line) tick_d = '0;
            else if (tick_q >= T_IDLE_END) state_d = IDLE;
         end
      endcase
      cmd_d = strobe_d ? rx_d : cmd_q;
      tx_d  = strobe_q ? ((cmd_q == JB_CMD_POLL) ? bus.cntlr_state : {JB_INFO_REPLY, 8'h00}) : tx_q;
   end

   // outputs: encoder kick-off at the end of the reply gap, reply-active while transmitting
   always_comb begin
      enc_start      = state_q == RSP_GAP && tick_q == T_GAP_END;
      bus.rsp_active = state_q == TX_BIT || state_q == TX_STOP;
   end

   assign bus.cmd_strobe = strobe_q;
   assign bus.cmd_byte   = cmd_q;
   assign bus.frame_err  = err_q;
   assign JB             = enc_drive ? 1'b0 : 1'bz;

   joybus_bit_encoder #(.US(US)) u_enc (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (enc_start),
      .data_i     (tx_q),
      .nbits_i    (tx_bits),
      .drive_low_o(enc_drive),
      .stop_o     (enc_stop),
      .done_o     (enc_done)
   );

endmodule

// File: doc/joybus_device.md
# joybus_device

Device-side (controller-end) JOYBUS endpoint: emulates an N64 controller on the single-wire open-drain bus. Decodes one-byte console commands and answers identity/reset (0x00/0xFF) and poll (0x01) requests with correctly timed reply frames, so an FPGA can stand in for a controller or loop back against our JOYBUS host. Sits at the top level beside the host, driving `JB` through an open-drain pad.

## Interface
- `CLK_MHZ`, default 25: clock frequency in MHz; defines the cycles per microsecond (`US` = `CLK_MHZ`).
- `IDLE_US`, default 64: microseconds of continuous line-high that re-arm the receiver after an ignored frame.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `JB`  inout  1  bus line; driven 0 or released to high-Z, never driven 1.
- `cntlr_state`  in  32  button/stick word, transmitted MSB first (A = bit 31).
- `cmd_strobe`  out  1  one-cycle pulse when a complete command byte is decoded.
- `cmd_byte`  out  8  last decoded command; valid while `cmd_strobe` is high, held afterwards.
- `rsp_active`  out  1  high from the first reply bit's falling edge through the end of the reply stop bit.
- `frame_err`  out  1  one-cycle pulse on a malformed or timed-out receive frame.

## Operation
- `JB` input passes through a 2-flop synchronizer. While this block drives the line, received activity is ignored.
- FSM states: IDLE, RX_SAMPLE, RX_HIGH, RX_STOP, RSP_GAP, TX_BIT, TX_STOP, DISCARD.
- IDLE: a synchronized falling edge -> RX_SAMPLE with the bit count at 0.
- RX_SAMPLE: at 2·US cycles after the falling edge, sample the line: high = 1, low = 0. Shift the bit in MSB-first, then -> RX_HIGH. If the line is still low at 5·US -> `frame_err`, DISCARD.
- RX_HIGH: wait for the line to go high, then for the next falling edge -> RX_SAMPLE. After bit 8, pulse `cmd_strobe` and -> RX_STOP. Line high for 8·US mid-byte -> `frame_err`, DISCARD.
- RX_STOP: expect the console stop pulse (falling edge, line back high within 2·US). On its rising edge: if the command is supported -> RSP_GAP; otherwise -> DISCARD. No falling edge within 8·US -> `frame_err`, DISCARD.
- Supported commands:
  - 0x00: reply 0x05, 0x00, 0x02 (3 bytes).
  - 0x01: reply `cntlr_state` (4 bytes), latched on the `cmd_strobe` cycle.
  - 0xFF: same reply as 0x00 (only when the configuration macro below is defined).
- RSP_GAP: 2·US cycles after the stop rising edge -> TX_BIT.
- TX_BIT: each bit lasts 4·US cycles, MSB first.
  - 0 = 3·US low, then 1·US released.
  - 1 = 1·US low, then 3·US released.
- TX_STOP: after the last bit, 2·US low, then release -> IDLE.
- DISCARD: wait for `IDLE_US`·US consecutive high cycles -> IDLE. Any falling edge restarts that count. Unsupported multi-byte commands (e.g. 0x02/0x03) are ridden out this way with no reply.

## Timing
- Reset values: `JB` released (high-Z), `cmd_strobe`=0, `cmd_byte`=0, `rsp_active`=0, `frame_err`=0, FSM in IDLE.
- Reset asserted mid-reply releases `JB` immediately (asynchronously).
- Synchronizer latency is 2 cycles. All intervals are measured from the synchronized edge; tolerance is ±2 cycles.
- `cmd_strobe` fires 1 cycle after the 8th sample.
- A reply's first falling edge occurs 2·US+1 cycles after the synchronized console-stop rising edge.
- Total reply length: 0x01 = 32·4·US + 2·US cycles; 0x00 = 24·4·US + 2·US cycles.
- `cntlr_state` changes after the latch cycle do not affect an in-flight reply.
- Counters saturate and never wrap. The bit counter is 6 bits and the tick counter is sized for `IDLE_US`·US.

## Configuration
- `JOYBUS_DEV_RESET_CMD_EN`
  - Defined: 0xFF is decoded as a supported command and answered exactly like 0x00.
  - Undefined: 0xFF is unsupported -> DISCARD, no reply. `cmd_strobe` still pulses with `cmd_byte`=0xFF.

## Structure
- Shared package `joybus_pkg` holds:
  - command constants: `JB_CMD_INFO`=0x00, `JB_CMD_POLL`=0x01, `JB_CMD_RESET`=0xFF;
  - the info-reply constant 0x050002;
  - bit-timing multipliers (1/2/3/4 µs);
  - the device FSM state enum.
- Sub-module `joybus_bit_encoder` turns a loaded shift register and a bit count into the timed low/release waveform (TX_BIT/TX_STOP) and signals done. The host transmitter can reuse the same encoder.

## Test plan
- Console model sends 0x01 + stop with `cntlr_state`=0x8000_1234 -> `cmd_strobe` with `cmd_byte`=0x01; 32 reply bits decode to 0x80001234, followed by a 2 µs stop low; `rsp_active` spans the whole reply.
- Send 0x00 -> reply bytes 0x05, 0x00, 0x02, first falling edge 2 µs after the console stop.
- Send 0x02 followed by 2 address bytes -> `cmd_strobe` with 0x02, no drive on `JB`, return to IDLE 64 µs after the last edge.
- Send 3 bits, then hold the line high 20 µs -> single `frame_err` pulse, no `cmd_strobe`, no reply.
- Send 0xFF, once with the macro defined and once without -> 0x05 0x00 0x02 reply vs. no reply.
- Assert `rst_n` low during the 10th reply bit -> `JB` is high-Z in the same timestep and all outputs return to 0; a subsequent 0x01 is answered normally.
